// File: rtl/alu_arb_pkg.sv
// Shared constants, state encoding and helpers for the round-robin ALU arbiter.
package alu_arb_pkg;

  localparam int unsigned N_REQ       = 8;
  localparam int unsigned SEL_W       = 3;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Binary index to one-hot requester vector.
  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner search starting just after the last owner.
module rr_pick
  import alu_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic             valid,
  output logic [SEL_W-1:0] index
);

  // First requester found at last+1, last+2, ... wrapping modulo N_REQ.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      if (!valid && req[SEL_W'(32'(last) + i)]) begin
        valid = 1'b1;
        index = SEL_W'(32'(last) + i);
      end
    end
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter granting a shared ALU to one of eight requesters,
// launching the operation and aborting it if completion never arrives.
module alu_rr_arbiter #(
  parameter int unsigned TIMEOUT = alu_arb_pkg::TIMEOUT_DEF,
  parameter int unsigned N_REQ   = alu_arb_pkg::N_REQ
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req,
  input  logic                          alu_done,
  output logic [N_REQ-1:0]              grant,
  output logic [alu_arb_pkg::SEL_W-1:0] sel,
  output logic                          alu_start,
  output logic                          busy,
  output logic                          timeout
);

  import alu_arb_pkg::*;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [SEL_W-1:0]   last;
  logic               pick_valid;
  logic [SEL_W-1:0]   pick_idx;

  rr_pick u_pick (
    .req   (req),
    .last  (last),
    .valid (pick_valid),
    .index (pick_idx)
  );

  // Arbitration FSM: grant in IDLE, pulse start, then wait for done or timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      sel       <= '0;
      busy      <= 1'b0;
      alu_start <= 1'b0;
      timeout   <= 1'b0;
      cnt       <= '0;
      last      <= SEL_W'(N_REQ - 1);
    end else begin
      alu_start <= 1'b0;
      timeout   <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant <= onehot(pick_idx);
            sel   <= pick_idx;
            busy  <= 1'b1;
            state <= START;
          end else begin
            grant <= '0;
            busy  <= 1'b0;
          end
        end
        START: begin
          alu_start <= 1'b1;
          cnt       <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          // Completion takes priority over a coincident terminal count.
          if (alu_done) begin
            last  <= sel;
            grant <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            timeout <= 1'b1;
            last    <= sel;
            grant   <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          grant <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed self-checking bench for alu_rr_arbiter.
module tb_alu_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       alu_done;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       alu_start;
  logic       busy;
  logic       timeout;

  int n_tests;
  int n_fail;
  int n_starts;

  alu_rr_arbiter #(.TIMEOUT(16), .N_REQ(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .alu_done  (alu_done),
    .grant     (grant),
    .sel       (sel),
    .alu_start (alu_start),
    .busy      (busy),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Structural invariants sampled every falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("onehot", 32'($countones(grant) <= 1), 32'd1);
      if (grant != 8'h00) check("sel_matches_grant", 32'(grant), 32'(8'h01 << sel));
    end
    if (alu_start) n_starts++;
  end

  task automatic do_reset();
    rst      = 1'b1;
    req      = 8'h00;
    alu_done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One full operation with done returned while alu_start is high; called at a falling edge in IDLE.
  task automatic run_op(input logic [7:0] r, input logic [2:0] exp_sel, input string tag);
    req = r;
    @(posedge clk); @(negedge clk);
    check({tag, "_sel"}, 32'(sel), 32'(exp_sel));
    check({tag, "_grant"}, 32'(grant), 32'(8'h01 << exp_sel));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    @(posedge clk); @(negedge clk);
    check({tag, "_start"}, 32'(alu_start), 32'd1);
    alu_done = 1'b1;
    @(posedge clk); @(negedge clk);
    alu_done = 1'b0;
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    n_starts = 0;
    rst      = 1'b1;
    req      = 8'h00;
    alu_done = 1'b0;
    #2;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_start", 32'(alu_start), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single requester 0, done one cycle after alu_start.
    req = 8'h01;
    @(posedge clk); @(negedge clk);
    check("r0_grant", 32'(grant), 32'h01);
    check("r0_sel", 32'(sel), 32'd0);
    check("r0_busy", 32'(busy), 32'd1);
    check("r0_nostart", 32'(alu_start), 32'd0);
    req = 8'h00;
    @(posedge clk); @(negedge clk);
    check("r0_start", 32'(alu_start), 32'd1);
    @(posedge clk); @(negedge clk);
    check("r0_start_once", 32'(alu_start), 32'd0);
    check("r0_still_busy", 32'(busy), 32'd1);
    alu_done = 1'b1;
    @(posedge clk); @(negedge clk);
    alu_done = 1'b0;
    check("r0_done_busy", 32'(busy), 32'd0);
    check("r0_done_grant", 32'(grant), 32'h0);
    check("r0_sel_hold", 32'(sel), 32'd0);
    @(posedge clk); @(negedge clk);
    check("r0_idle_grant", 32'(grant), 32'h0);

    // Fairness: all requesting, grants rotate 0..7,0.
    do_reset();
    n_starts = 0;
    for (int i = 0; i < 9; i++) run_op(8'hFF, 3'(i), "rr");
    check("rr_start_count", 32'(n_starts), 32'd9);
    req = 8'h00;

    // Rotation from last=2 with requesters 1 and 7.
    do_reset();
    run_op(8'h04, 3'd2, "set_last2");
    run_op(8'h82, 3'd7, "wrap_first");
    run_op(8'h82, 3'd1, "wrap_second");
    req = 8'h00;

    // Timeout: requester 4, done never returned.
    do_reset();
    req = 8'h10;
    @(posedge clk); @(negedge clk);
    check("to_grant", 32'(grant), 32'h10);
    @(posedge clk); @(negedge clk);
    check("to_start", 32'(alu_start), 32'd1);
    for (int j = 2; j <= 16; j++) begin
      @(posedge clk); @(negedge clk);
      check("to_early", 32'({timeout, busy}), 32'b01);
    end
    @(posedge clk); @(negedge clk);
    check("to_pulse", 32'(timeout), 32'd1);
    check("to_grant_clr", 32'(grant), 32'h0);
    check("to_busy_clr", 32'(busy), 32'd0);
    @(posedge clk); @(negedge clk);
    check("to_pulse_end", 32'(timeout), 32'd0);
    check("to_regrant", 32'(grant), 32'h10);
    req = 8'h00;
    alu_done = 1'b1;
    @(posedge clk); @(negedge clk);
    check("done_in_start_ignored", 32'({alu_start, busy}), 32'b11);
    @(posedge clk); @(negedge clk);
    alu_done = 1'b0;
    check("to_final_idle", 32'(busy), 32'd0);

    // Granted requester drops req mid-operation; grant persists.
    do_reset();
    req = 8'h60;
    @(posedge clk); @(negedge clk);
    check("hold_grant0", 32'(grant), 32'h20);
    req = 8'h40;
    @(posedge clk); @(negedge clk);
    check("hold_grant1", 32'(grant), 32'h20);
    @(posedge clk); @(negedge clk);
    check("hold_grant2", 32'(grant), 32'h20);
    alu_done = 1'b1;
    @(posedge clk); @(negedge clk);
    alu_done = 1'b0;
    check("hold_released", 32'(grant), 32'h0);
    @(posedge clk); @(negedge clk);
    check("hold_next_grant", 32'(grant), 32'h40);
    check("hold_next_sel", 32'(sel), 32'd6);

    // Asynchronous reset in WAIT with sel=3.
    do_reset();
    req = 8'h08;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check("ar_pre_sel", 32'(sel), 32'd3);
    check("ar_pre_busy", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("ar_grant", 32'(grant), 32'h0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_sel", 32'(sel), 32'd0);
    alu_done = 1'b1;
    @(posedge clk); @(negedge clk);
    check("ar_no_timeout", 32'(timeout), 32'd0);
    alu_done = 1'b0;
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("ar_post_grant", 32'(grant), 32'h08);
    check("ar_post_sel", 32'(sel), 32'd3);
    req = 8'h00;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
